// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control path: FSM states,
// opcodes, the ALUOp codes understood by the ALU control decoder, and
// datapath mux select codes.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_R_EXEC   = 4'd2,
        S_R_WB     = 4'd3,
        S_I_EXEC   = 4'd4,
        S_I_WB     = 4'd5,
        S_MEM_ADDR = 4'd6,
        S_MEM_RD   = 4'd7,
        S_MEM_WB   = 4'd8,
        S_MEM_WR   = 4'd9,
        S_BRANCH   = 4'd10,
        S_JUMP     = 4'd11,
        S_JR       = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FUNCT_JR = 6'b001000;

    localparam logic [3:0] ALUOP_ADD   = 4'b0000;
    localparam logic [3:0] ALUOP_ADDI  = 4'b0000;
    localparam logic [3:0] ALUOP_ORI   = 4'b0001;
    localparam logic [3:0] ALUOP_ANDI  = 4'b0010;
    localparam logic [3:0] ALUOP_LUI   = 4'b0011;
    localparam logic [3:0] ALUOP_LW    = 4'b0100;
    localparam logic [3:0] ALUOP_SW    = 4'b0101;
    localparam logic [3:0] ALUOP_RTYPE = 4'b0111;
    localparam logic [3:0] ALUOP_BEQ   = 4'b1000;
    localparam logic [3:0] ALUOP_BNE   = 4'b1001;

    localparam logic [1:0] REG_DST_RT = 2'b00;
    localparam logic [1:0] REG_DST_RD = 2'b01;
    localparam logic [1:0] REG_DST_RA = 2'b10;

    localparam logic [1:0] WB_ALUOUT = 2'b00;
    localparam logic [1:0] WB_MDR    = 2'b01;
    localparam logic [1:0] WB_PC     = 2'b10;

    localparam logic SRC_A_PC  = 1'b0;
    localparam logic SRC_A_REG = 1'b1;

    localparam logic [1:0] SRC_B_REG     = 2'b00;
    localparam logic [1:0] SRC_B_FOUR    = 2'b01;
    localparam logic [1:0] SRC_B_IMM     = 2'b10;
    localparam logic [1:0] SRC_B_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] PCSRC_REG    = 2'b11;

    // State entered after DECODE; FETCH means the opcode is unsupported.
    function automatic state_t decode_target(input logic [5:0] op, input logic [5:0] fn);
        state_t t;
        case (op)
            OP_RTYPE:                         t = (fn == FUNCT_JR) ? S_JR : S_R_EXEC;
            OP_LW, OP_SW:                     t = S_MEM_ADDR;
            OP_ADDI, OP_ORI, OP_ANDI, OP_LUI: t = S_I_EXEC;
            OP_BEQ, OP_BNE:                   t = S_BRANCH;
            OP_J, OP_JAL:                     t = S_JUMP;
            default:                          t = S_FETCH;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/alu_op_encoder.sv
// Opcode to ALUOp translation for the states that let the instruction
// choose the ALU operation (I-type execute, address calc, branch compare).
module alu_op_encoder
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    output logic [3:0] alu_op
);

    // Pure lookup; unknown opcodes fall back to add.
    always_comb begin
        case (opcode)
            OP_RTYPE: alu_op = ALUOP_RTYPE;
            OP_ADDI:  alu_op = ALUOP_ADDI;
            OP_ORI:   alu_op = ALUOP_ORI;
            OP_ANDI:  alu_op = ALUOP_ANDI;
            OP_LUI:   alu_op = ALUOP_LUI;
            OP_LW:    alu_op = ALUOP_LW;
            OP_SW:    alu_op = ALUOP_SW;
            OP_BEQ:   alu_op = ALUOP_BEQ;
            OP_BNE:   alu_op = ALUOP_BNE;
            default:  alu_op = ALUOP_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle main control FSM: steps each instruction through fetch,
// decode, execute, memory and writeback, driving datapath enables/muxes.
module multicycle_control
    import mips_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic [1:0] reg_dst,
    output logic [1:0] mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_source,
    output logic [3:0] alu_op,
    output logic       instr_done,
    output logic       illegal,
    output logic [3:0] state_o
);

    state_t     state;
    logic [3:0] enc_alu_op;

    alu_op_encoder u_alu_op_encoder (
        .opcode (opcode),
        .alu_op (enc_alu_op)
    );

    assign state_o = state;

    // State register with synchronous active-low reset and next-state sequencing
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= S_FETCH;
        end else begin
            case (state)
                S_FETCH:    if (mem_ready) state <= S_DECODE;
                S_DECODE:   state <= decode_target(opcode, funct);
                S_R_EXEC:   state <= S_R_WB;
                S_I_EXEC:   state <= S_I_WB;
                S_MEM_ADDR: state <= (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
                S_MEM_RD:   if (mem_ready) state <= S_MEM_WB;
                S_MEM_WR:   if (mem_ready) state <= S_FETCH;
                // Final single-cycle states and unused encodings all return to fetch.
                default:    state <= S_FETCH;
            endcase
        end
    end

    // Output decode from the current state (plus mem_ready/zero where they gate enables)
    always_comb begin
        pc_write   = 1'b0;
        i_or_d     = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = REG_DST_RT;
        mem_to_reg = WB_ALUOUT;
        alu_src_a  = SRC_A_PC;
        alu_src_b  = SRC_B_REG;
        pc_source  = PCSRC_ALU;
        alu_op     = ALUOP_ADD;
        instr_done = 1'b0;
        illegal    = 1'b0;
        case (state)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRC_B_FOUR;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE: begin
                alu_src_b = SRC_B_IMM_SH2;
                illegal   = (decode_target(opcode, funct) == S_FETCH);
            end
            S_R_EXEC: begin
                alu_src_a = SRC_A_REG;
                alu_src_b = SRC_B_REG;
                alu_op    = ALUOP_RTYPE;
            end
            S_R_WB: begin
                reg_write  = 1'b1;
                reg_dst    = REG_DST_RD;
                instr_done = 1'b1;
            end
            S_I_EXEC, S_MEM_ADDR: begin
                alu_src_a = SRC_A_REG;
                alu_src_b = SRC_B_IMM;
                alu_op    = enc_alu_op;
            end
            S_I_WB: begin
                reg_write  = 1'b1;
                reg_dst    = REG_DST_RT;
                instr_done = 1'b1;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = WB_MDR;
                instr_done = 1'b1;
            end
            S_MEM_WR: begin
                mem_write  = 1'b1;
                i_or_d     = 1'b1;
                instr_done = mem_ready;
            end
            S_BRANCH: begin
                alu_src_a  = SRC_A_REG;
                alu_src_b  = SRC_B_REG;
                alu_op     = enc_alu_op;
                pc_source  = PCSRC_ALUOUT;
                instr_done = 1'b1;
                pc_write   = ((opcode == OP_BEQ) && zero) || ((opcode == OP_BNE) && !zero);
            end
            S_JUMP: begin
                pc_source  = PCSRC_JUMP;
                pc_write   = 1'b1;
                instr_done = 1'b1;
                if (opcode == OP_JAL) begin
                    reg_write  = 1'b1;
                    reg_dst    = REG_DST_RA;
                    mem_to_reg = WB_PC;
                end
            end
            S_JR: begin
                pc_source  = PCSRC_REG;
                pc_write   = 1'b1;
                instr_done = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: an instruction-level model
// expands each instruction into its expected per-cycle trace, which is
// then driven and compared cycle by cycle.
module tb_multicycle_control;
    import mips_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       pc_write, i_or_d, mem_read, mem_write, ir_write, reg_write;
    logic [1:0] reg_dst, mem_to_reg, alu_src_b, pc_source;
    logic       alu_src_a, instr_done, illegal;
    logic [3:0] alu_op, state_o;

    multicycle_control dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .funct      (funct),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .pc_write   (pc_write),
        .i_or_d     (i_or_d),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .ir_write   (ir_write),
        .reg_write  (reg_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .pc_source  (pc_source),
        .alu_op     (alu_op),
        .instr_done (instr_done),
        .illegal    (illegal),
        .state_o    (state_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       pc_write;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic [3:0] alu_op;
        logic       instr_done;
        logic       illegal;
    } outs_t;

    // One cycle: inputs to drive plus the outputs they must produce.
    typedef struct packed {
        logic       rst;
        logic       mr;
        logic       zr;
        logic [5:0] op;
        logic [5:0] fn;
        logic [3:0] st;
        outs_t      o;
    } rec_t;

    typedef enum logic [3:0] {C_R, C_JR, C_I, C_LW, C_SW, C_BR, C_J, C_JAL, C_ILL} cls_t;

    outs_t dut_o;
    assign dut_o = {pc_write, i_or_d, mem_read, mem_write, ir_write, reg_write, reg_dst,
                    mem_to_reg, alu_src_a, alu_src_b, pc_source, alu_op, instr_done, illegal};

    rec_t        q[$];
    int unsigned total = 0;
    int unsigned bad   = 0;

    function automatic cls_t classify(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            6'b000000: return (fn == 6'b001000) ? C_JR : C_R;
            6'b001000, 6'b001101, 6'b001100, 6'b001111: return C_I;
            6'b100011: return C_LW;
            6'b101011: return C_SW;
            6'b000100, 6'b000101: return C_BR;
            6'b000010: return C_J;
            6'b000011: return C_JAL;
            default:   return C_ILL;
        endcase
    endfunction

    function automatic logic [3:0] model_aluop(input logic [5:0] op);
        case (op)
            6'b001000: return 4'b0000;
            6'b001101: return 4'b0001;
            6'b001100: return 4'b0010;
            6'b001111: return 4'b0011;
            6'b100011: return 4'b0100;
            6'b101011: return 4'b0101;
            6'b000100: return 4'b1000;
            6'b000101: return 4'b1001;
            default:   return 4'b0000;
        endcase
    endfunction

    function automatic rec_t blank(input logic [3:0] st, input logic [5:0] op, input logic [5:0] fn);
        rec_t r;
        r     = '0;
        r.rst = 1'b1;
        r.mr  = 1'($urandom);
        r.zr  = 1'($urandom);
        r.op  = op;
        r.fn  = fn;
        r.st  = st;
        return r;
    endfunction

    function automatic rec_t fetch_rec(input logic mr);
        rec_t r;
        r = blank(S_FETCH, 6'($urandom), 6'($urandom));
        r.mr          = mr;
        r.o.mem_read  = 1'b1;
        r.o.alu_src_b = 2'b01;
        r.o.ir_write  = mr;
        r.o.pc_write  = mr;
        return r;
    endfunction

    // Expand one instruction into its expected cycle trace.
    task automatic plan(input logic [5:0] op, input logic [5:0] fn, input int unsigned fst,
                        input int unsigned mst, input logic z, input bit abort);
        rec_t r;
        cls_t c;
        c = classify(op, fn);
        for (int unsigned i = 0; i < fst; i++) q.push_back(fetch_rec(1'b0));
        q.push_back(fetch_rec(1'b1));
        r = blank(S_DECODE, op, fn);
        r.o.alu_src_b = 2'b11;
        r.o.illegal   = (c == C_ILL);
        q.push_back(r);
        case (c)
            C_R: begin
                r = blank(S_R_EXEC, op, fn);
                r.o.alu_src_a = 1'b1; r.o.alu_op = 4'b0111;
                q.push_back(r);
                r = blank(S_R_WB, op, fn);
                r.o.reg_write = 1'b1; r.o.reg_dst = 2'b01; r.o.instr_done = 1'b1;
                q.push_back(r);
            end
            C_I: begin
                r = blank(S_I_EXEC, op, fn);
                r.o.alu_src_a = 1'b1; r.o.alu_src_b = 2'b10; r.o.alu_op = model_aluop(op);
                q.push_back(r);
                r = blank(S_I_WB, op, fn);
                r.o.reg_write = 1'b1; r.o.instr_done = 1'b1;
                q.push_back(r);
            end
            C_LW, C_SW: begin
                r = blank(S_MEM_ADDR, op, fn);
                r.o.alu_src_a = 1'b1; r.o.alu_src_b = 2'b10; r.o.alu_op = model_aluop(op);
                q.push_back(r);
                for (int unsigned i = 0; i <= mst; i++) begin
                    r = blank((c == C_LW) ? S_MEM_RD : S_MEM_WR, op, fn);
                    r.mr          = (i == mst);
                    r.o.i_or_d    = 1'b1;
                    r.o.mem_read  = (c == C_LW);
                    r.o.mem_write = (c == C_SW);
                    r.o.instr_done = (c == C_SW) && (i == mst);
                    if (abort && i == mst) begin
                        // Hold reset low for two edges instead of completing the access.
                        r.mr = 1'b0; r.rst = 1'b0; r.o.instr_done = 1'b0;
                        q.push_back(r);
                        r = fetch_rec(1'b0);
                        r.rst = 1'b0;
                        q.push_back(r);
                        return;
                    end
                    q.push_back(r);
                end
                if (c == C_LW) begin
                    r = blank(S_MEM_WB, op, fn);
                    r.o.reg_write = 1'b1; r.o.mem_to_reg = 2'b01; r.o.instr_done = 1'b1;
                    q.push_back(r);
                end
            end
            C_BR: begin
                r = blank(S_BRANCH, op, fn);
                r.zr = z;
                r.o.alu_src_a = 1'b1; r.o.alu_op = model_aluop(op);
                r.o.pc_source = 2'b01; r.o.instr_done = 1'b1;
                r.o.pc_write  = (op == 6'b000100) ? z : !z;
                q.push_back(r);
            end
            C_J, C_JAL: begin
                r = blank(S_JUMP, op, fn);
                r.o.pc_source = 2'b10; r.o.pc_write = 1'b1; r.o.instr_done = 1'b1;
                if (c == C_JAL) begin
                    r.o.reg_write = 1'b1; r.o.reg_dst = 2'b10; r.o.mem_to_reg = 2'b10;
                end
                q.push_back(r);
            end
            C_JR: begin
                r = blank(S_JR, op, fn);
                r.o.pc_source = 2'b11; r.o.pc_write = 1'b1; r.o.instr_done = 1'b1;
                q.push_back(r);
            end
            default: ;
        endcase
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
        end
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin : run
        rec_t        r;
        rec_t        t;
        int          n0;
        logic [5:0]  op;
        logic [5:0]  fn;

        reset = 1'b0; mem_ready = 1'b0; zero = 1'b0; opcode = '0; funct = '0;

        // Reset cycles: FETCH with memory not ready, nothing enabled.
        for (int i = 0; i < 2; i++) begin
            r = fetch_rec(1'b0);
            r.rst = 1'b0;
            q.push_back(r);
        end

        // Directed instructions, with the model's trace pinned to hand-computed values.
        n0 = q.size(); plan(6'b000000, 6'b100000, 0, 0, 1'b0, 1'b0);
        check("len_add", 32'(q.size() - n0), 4);
        t = q[q.size()-1];
        check("add_wb", {t.o.reg_write, t.o.reg_dst, t.o.instr_done}, 4'b1011);

        n0 = q.size(); plan(6'b100011, 6'($urandom), 0, 3, 1'b0, 1'b0);
        check("len_lw_stall3", 32'(q.size() - n0), 8);
        t = q[q.size()-1];
        check("lw_wb", {t.o.reg_write, t.o.mem_to_reg}, 3'b101);

        n0 = q.size(); plan(6'b000100, 6'($urandom), 0, 0, 1'b1, 1'b0);
        check("len_beq", 32'(q.size() - n0), 3);
        t = q[q.size()-1];
        check("beq_taken", {t.o.pc_write, t.o.alu_op}, 5'b11000);

        n0 = q.size(); plan(6'b000101, 6'($urandom), 0, 0, 1'b1, 1'b0);
        t = q[q.size()-1];
        check("bne_not_taken", {t.o.pc_write, t.o.alu_op}, 5'b01001);

        n0 = q.size(); plan(6'b000011, 6'($urandom), 0, 0, 1'b0, 1'b0);
        check("len_jal", 32'(q.size() - n0), 3);
        t = q[q.size()-1];
        check("jal_link", {t.o.pc_write, t.o.reg_write, t.o.reg_dst, t.o.mem_to_reg}, 6'b111010);

        plan(6'b000000, 6'b001000, 0, 0, 1'b0, 1'b0);
        t = q[q.size()-1];
        check("jr_src", t.o.pc_source, 2'b11);

        n0 = q.size(); plan(6'b111111, 6'($urandom), 0, 0, 1'b0, 1'b0);
        check("len_illegal", 32'(q.size() - n0), 2);
        t = q[q.size()-1];
        check("illegal_flag", {t.o.illegal, t.o.reg_write, t.o.pc_write}, 3'b100);

        // Reset mid-LW while in the memory-read stall.
        plan(6'b100011, 6'($urandom), 1, 1, 1'b0, 1'b1);
        plan(6'b101011, 6'($urandom), 0, 2, 1'b0, 1'b0);

        // Randomized instruction stream with random memory stalls.
        for (int i = 0; i < 400; i++) begin
            fn = 6'($urandom);
            case ($urandom_range(0, 12))
                0:  op = 6'b000000;
                1:  begin op = 6'b000000; fn = 6'b001000; end
                2:  op = 6'b001000;
                3:  op = 6'b001101;
                4:  op = 6'b001100;
                5:  op = 6'b001111;
                6:  op = 6'b100011;
                7:  op = 6'b101011;
                8:  op = 6'b000100;
                9:  op = 6'b000101;
                10: op = 6'b000010;
                11: op = 6'b000011;
                default: op = 6'($urandom);
            endcase
            plan(op, fn,
                 ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3),
                 ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3),
                 1'($urandom), ($urandom_range(0, 29) == 0));
        end

        // Drive each cycle after the edge, compare on the falling edge.
        @(posedge clk);
        while (q.size() > 0) begin
            #1;
            r = q.pop_front();
            reset     = r.rst;
            mem_ready = r.mr;
            zero      = r.zr;
            opcode    = r.op;
            funct     = r.fn;
            @(negedge clk);
            check("state", 32'(state_o), 32'(r.st));
            check("outs", 32'(dut_o), 32'(r.o));
            if (mem_read && mem_write) check("rd_wr_exclusive", 1, 0);
            @(posedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
